// File: rtl/intra16_pred_sched_pkg.sv
// Shared types, encodings and mode-selection helpers for the 16x16 intra-prediction scheduler.
package intra_pred_pkg;

  localparam int unsigned BLOCK_NUM_DEF = 10;
  localparam int unsigned MODE_CNT      = 4;
  localparam int unsigned MODE_W        = 2;
  localparam int unsigned TIMEOUT_DEF   = 64;

  // 16x16 prediction modes, launched in ascending order
  localparam logic [MODE_W-1:0] MODE_DC = 2'd0;
  localparam logic [MODE_W-1:0] MODE_TM = 2'd1;
  localparam logic [MODE_W-1:0] MODE_VE = 2'd2;
  localparam logic [MODE_W-1:0] MODE_HE = 2'd3;

  // One-hot scheduler states
  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_LAUNCH = 5'b00010,
    ST_WAIT   = 5'b00100,
    ST_PUSH   = 5'b01000,
    ST_FIN    = 5'b10000
  } state_e;

  // Result of a mode search: found=0 means no enabled mode above cur
  typedef struct packed {
    logic              found;
    logic [MODE_W-1:0] mode;
  } mode_pick_t;

  // Lowest enabled mode strictly above cur
  function automatic mode_pick_t first_mode_above(input logic [MODE_CNT-1:0] mask,
                                                  input logic [MODE_W-1:0]   cur);
    mode_pick_t r;
    r = '0;
    for (int i = int'(MODE_CNT) - 1; i >= 0; i--) begin
      if ((i > int'(cur)) && mask[i]) begin
        r.found = 1'b1;
        r.mode  = MODE_W'(i);
      end
    end
    return r;
  endfunction

  // Lowest enabled mode in the mask (DC when mask is empty)
  function automatic logic [MODE_W-1:0] first_mode(input logic [MODE_CNT-1:0] mask);
    logic [MODE_W-1:0] m;
    m = '0;
    for (int i = int'(MODE_CNT) - 1; i >= 0; i--) begin
      if (mask[i]) m = MODE_W'(i);
    end
    return m;
  endfunction

endpackage

// File: rtl/intra16_pred_sched_if.sv
// Request, engine-control and result signals between encoder control, scheduler and predictor.
interface intra16_pred_sched_if #(
  parameter int unsigned BLOCK_NUM = 10,
  parameter int unsigned MODE_NUM  = 4
);

  logic                 req_valid;
  logic                 req_ready;
  logic [BLOCK_NUM-1:0] req_x;
  logic [BLOCK_NUM-1:0] req_y;
  logic [MODE_NUM-1:0]  req_mask;

  logic                 eng_start;
  logic [1:0]           eng_mode;
  logic [BLOCK_NUM-1:0] eng_x;
  logic [BLOCK_NUM-1:0] eng_y;
  logic                 eng_done;

  logic                 res_valid;
  logic                 res_ready;
  logic [1:0]           res_mode;
  logic                 res_last;

  logic                 mb_done;
  logic                 busy;
  logic                 err_timeout;

  // Scheduler side
  modport master (
    input  req_valid, req_x, req_y, req_mask, eng_done, res_ready,
    output req_ready, eng_start, eng_mode, eng_x, eng_y,
           res_valid, res_mode, res_last, mb_done, busy, err_timeout
  );

  // Environment side: encoder control, predictor and cost evaluator
  modport slave (
    output req_valid, req_x, req_y, req_mask, eng_done, res_ready,
    input  req_ready, eng_start, eng_mode, eng_x, eng_y,
           res_valid, res_mode, res_last, mb_done, busy, err_timeout
  );

endinterface

// File: rtl/intra16_pred_sched_mode_pick.sv
// Combinational next-mode selector: next enabled mode above the current one, and the last flag.
module intra_mode_pick
  import intra_pred_pkg::*;
#(
  parameter int unsigned MODE_NUM = 4
) (
  input  logic [MODE_NUM-1:0] mask,
  input  logic [MODE_W-1:0]   cur_mode,
  output logic [MODE_W-1:0]   next_mode_c,
  output logic                last_c
);

  mode_pick_t pick;

  // Search the mask above the current mode
  always_comb begin
    pick        = first_mode_above(mask, cur_mode);
    next_mode_c = pick.mode;
    last_c      = ~pick.found;
  end

endmodule

// File: rtl/intra16_pred_sched.sv
// Sequences one shared 16x16 intra-prediction engine through the enabled modes of one macroblock,
// forwarding each finished prediction to the cost evaluator over valid/ready.
module intra16_pred_sched
  import intra_pred_pkg::*;
#(
  parameter int unsigned BLOCK_NUM = BLOCK_NUM_DEF,
  parameter int unsigned MODE_NUM  = MODE_CNT,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  intra16_pred_sched_if.master bus
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [BLOCK_NUM-1:0] x_q, x_d;
  logic [BLOCK_NUM-1:0] y_q, y_d;
  logic [MODE_NUM-1:0]  mask_q, mask_d;
  logic [MODE_W-1:0]    mode_q, mode_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [MODE_W-1:0]    res_mode_q, res_mode_d;
  logic                 res_last_q, res_last_d;
  logic                 req_ready_q, req_ready_d;
  logic                 eng_start_q, eng_start_d;
  logic                 res_valid_q, res_valid_d;
  logic                 mb_done_q, mb_done_d;
  logic                 busy_q, busy_d;

  logic [MODE_W-1:0]    pick_next_c;
  logic                 pick_last_c;

  // Next enabled mode after the one currently in flight
  intra_mode_pick #(
    .MODE_NUM (MODE_NUM)
  ) u_mode_pick (
    .mask        (mask_q),
    .cur_mode    (mode_q),
    .next_mode_c (pick_next_c),
    .last_c      (pick_last_c)
  );

  // State register, latched MB context and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      mask_q      <= '0;
      mode_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      res_mode_q  <= '0;
      res_last_q  <= 1'b0;
      req_ready_q <= 1'b1;
      eng_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      mb_done_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      res_mode_q  <= res_mode_d;
      res_last_q  <= res_last_d;
      req_ready_q <= req_ready_d;
      eng_start_q <= eng_start_d;
      res_valid_q <= res_valid_d;
      mb_done_q   <= mb_done_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register in step with it
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    mask_d     = mask_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    res_mode_d = res_mode_q;
    res_last_d = res_last_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          x_d    = bus.req_x;
          y_d    = bus.req_y;
          mask_d = bus.req_mask;
          err_d  = 1'b0;
          if (|bus.req_mask) begin
            mode_d  = first_mode(bus.req_mask);
            state_d = ST_LAUNCH;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_LAUNCH: begin
        // A done seen during the start cycle belongs to no launch of ours
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.eng_done) begin
          res_mode_d = mode_q;
          res_last_d = pick_last_c;
          state_d    = ST_PUSH;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PUSH: begin
        if (bus.res_ready) begin
          if (res_last_q) begin
            state_d = ST_FIN;
          end else begin
            mode_d  = pick_next_c;
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
    eng_start_d = (state_d == ST_LAUNCH);
    res_valid_d = (state_d == ST_PUSH);
    mb_done_d   = (state_d == ST_FIN);
    busy_d      = (state_d != ST_IDLE);
  end

  // Drive the interface from the registers
  assign bus.req_ready   = req_ready_q;
  assign bus.eng_start   = eng_start_q;
  assign bus.eng_mode    = mode_q;
  assign bus.eng_x       = x_q;
  assign bus.eng_y       = y_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_mode    = res_mode_q;
  assign bus.res_last    = res_last_q;
  assign bus.mb_done     = mb_done_q;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_intra16_pred_sched.sv
// Bench for intra16_pred_sched: a latency-programmable engine model plus a per-MB timeline model
// that predicts every cycle's control outputs from the mask, engine latency and ready pattern.
module tb_intra16_pred_sched;

  localparam int TIMEOUT = 64;
  localparam int MAXC    = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  intra16_pred_sched_if #(.BLOCK_NUM(10), .MODE_NUM(4)) bus ();

  intra16_pred_sched #(
    .BLOCK_NUM (10),
    .MODE_NUM  (4),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_errors  = 0;
  bit model_err = 1'b0;

  // Engine model: done arrives eng_lat cycles after the start cycle unless hung;
  // eng_glitch adds a stray done during the start cycle itself.
  int eng_lat    = 4;
  bit eng_hang   = 1'b0;
  bit eng_glitch = 1'b0;
  bit eng_pend   = 1'b0;
  int eng_left   = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      eng_pend     = 1'b0;
      bus.eng_done = 1'b0;
    end else begin
      bus.eng_done = 1'b0;
      if (eng_pend) begin
        eng_left = eng_left - 1;
        if (eng_left == 0) begin
          bus.eng_done = !eng_hang;
          eng_pend     = 1'b0;
        end
      end
      if (bus.eng_start === 1'b1) begin
        eng_pend = 1'b1;
        eng_left = eng_lat;
        if (eng_glitch) bus.eng_done = 1'b1;
      end
    end
  end

  // Compare every output against its reset value
  task automatic check_reset_outputs(input string name);
    n_checks++;
    if ({bus.req_ready, bus.busy, bus.eng_start, bus.res_valid, bus.mb_done, bus.err_timeout,
         bus.res_last, bus.res_mode, bus.eng_mode, bus.eng_x, bus.eng_y} !== {6'b100000, 1'b0, 24'd0}) begin
      n_errors++;
      $display("FAIL %s: rdy/busy/start/valid/done/err=%b last=%b res_mode=%0d eng_mode=%0d x=%0d y=%0d, expected 100000 and zeros",
               name, {bus.req_ready, bus.busy, bus.eng_start, bus.res_valid, bus.mb_done, bus.err_timeout},
               bus.res_last, bus.res_mode, bus.eng_mode, bus.eng_x, bus.eng_y);
    end
  endtask

  // One macroblock: build the expected timeline, then drive and compare cycle by cycle.
  // Cycle 0 is the accept cycle. abort_at>0 pulls reset at that cycle instead of finishing.
  task automatic run_mb(input string name, input logic [3:0] mask, input int lat, input bit hang,
                        input int stall_pct, input int stall_from, input int stall_len,
                        input int abort_at, output int act_fin, output int act_starts);
    bit   rdy[MAXC];
    bit   e_start[MAXC];
    bit   e_valid[MAXC];
    bit   e_last[MAXC];
    bit   e_has[MAXC];
    int   e_mode[MAXC];
    int   modes[$];
    int   t, h, fin;
    bit   err_end;
    logic [9:0] x, y;
    logic [4:0] act_v, exp_v;

    x = 10'($urandom);
    y = 10'($urandom);
    for (int c = 0; c < MAXC; c++) begin
      rdy[c]     = (c >= 512) || (int'($urandom_range(99)) >= stall_pct);
      if (c >= stall_from && c < stall_from + stall_len) rdy[c] = 1'b0;
      e_start[c] = 1'b0;
      e_valid[c] = 1'b0;
      e_last[c]  = 1'b0;
      e_has[c]   = 1'b0;
      e_mode[c]  = 0;
    end

    // Reference timeline: modes in ascending order, each start one cycle after the previous handshake
    for (int m = 0; m < 4; m++) if (mask[m]) modes.push_back(m);
    t       = 1;
    fin     = 1;
    err_end = 1'b0;
    for (int i = 0; i < modes.size(); i++) begin
      e_start[t] = 1'b1;
      if (hang) begin
        fin     = t + 1 + TIMEOUT;
        err_end = 1'b1;
        for (int c = t; c < fin; c++) begin e_has[c] = 1'b1; e_mode[c] = modes[i]; end
        break;
      end
      h = t + lat + 1;
      while (!rdy[h]) h++;
      for (int c = t; c <= h; c++) begin e_has[c] = 1'b1; e_mode[c] = modes[i]; end
      for (int c = t + lat + 1; c <= h; c++) begin
        e_valid[c] = 1'b1;
        e_last[c]  = (i == modes.size() - 1);
      end
      t   = h + 1;
      fin = t;
    end

    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.err_timeout !== model_err) begin
      n_errors++;
      $display("FAIL %s idle: req_ready=%b err_timeout=%b, expected 1 and %b", name,
               bus.req_ready, bus.err_timeout, model_err);
    end
    eng_lat       = lat;
    eng_hang      = hang;
    eng_glitch    = 1'($urandom_range(1));
    bus.req_valid = 1'b1;
    bus.req_x     = x;
    bus.req_y     = y;
    bus.req_mask  = mask;
    bus.res_ready = rdy[0];
    act_fin       = -1;
    act_starts    = 0;

    for (int c = 1; c <= fin + 1; c++) begin
      @(negedge clk);
      if (abort_at > 0 && c == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs({name, " async reset"});
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        model_err = 1'b0;
        return;
      end
      if (bus.mb_done === 1'b1 && act_fin < 0) act_fin = c;
      if (bus.eng_start === 1'b1) act_starts++;

      exp_v = {c > fin, c <= fin, e_start[c], e_valid[c], c == fin};
      act_v = {bus.req_ready, bus.busy, bus.eng_start, bus.res_valid, bus.mb_done};
      n_checks++;
      if (act_v !== exp_v) begin
        n_errors++;
        $display("FAIL %s ctl c=%0d: rdy/busy/start/valid/done=%b, expected %b", name, c, act_v, exp_v);
      end
      if (e_valid[c]) begin
        n_checks++;
        if ({bus.res_mode, bus.res_last} !== {2'(e_mode[c]), e_last[c]}) begin
          n_errors++;
          $display("FAIL %s result c=%0d: mode=%0d last=%b, expected mode=%0d last=%b", name, c,
                   bus.res_mode, bus.res_last, e_mode[c], e_last[c]);
        end
      end
      if (e_has[c]) begin
        n_checks++;
        if (bus.eng_mode !== 2'(e_mode[c])) begin
          n_errors++;
          $display("FAIL %s eng_mode c=%0d: %0d, expected %0d", name, c, bus.eng_mode, e_mode[c]);
        end
      end
      n_checks++;
      if ({bus.eng_x, bus.eng_y, bus.err_timeout} !== {x, y, 1'(err_end && c >= fin)}) begin
        n_errors++;
        $display("FAIL %s ctx c=%0d: x=%0d y=%0d err=%b, expected x=%0d y=%0d err=%b", name, c,
                 bus.eng_x, bus.eng_y, bus.err_timeout, x, y, err_end && c >= fin);
      end

      // Requests during the MB must be ignored; none may be pending once IDLE returns
      bus.req_valid = (c <= fin) ? 1'($urandom_range(1)) : 1'b0;
      bus.req_x     = 10'($urandom);
      bus.req_y     = 10'($urandom);
      bus.req_mask  = 4'($urandom);
      bus.res_ready = rdy[c];
    end
    bus.res_ready = 1'b0;
    model_err     = err_end;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_mask  = '0;
    bus.res_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #1 rst_n = 1'b1;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_full_mask();
    int fin, starts;
    run_mb("full_mask", 4'b1111, 17, 1'b0, 0, -1, 0, 0, fin, starts);
    n_checks++;
    if (fin !== 4 * 19 + 1 || starts !== 4) begin
      n_errors++;
      $display("FAIL full_mask totals: mb_done at %0d with %0d starts, expected 77 and 4", fin, starts);
    end
  endtask

  task automatic test_sparse_mask();
    int fin, starts;
    run_mb("sparse_mask", 4'b0101, int'($urandom_range(3, 12)), 1'b0, 30, -1, 0, 0, fin, starts);
    n_checks++;
    if (starts !== 2) begin
      n_errors++;
      $display("FAIL sparse_mask starts: %0d, expected 2", starts);
    end
  endtask

  task automatic test_empty_mask();
    int fin, starts;
    run_mb("empty_mask", 4'b0000, 5, 1'b0, 0, -1, 0, 0, fin, starts);
    n_checks++;
    if (fin !== 1 || starts !== 0) begin
      n_errors++;
      $display("FAIL empty_mask: mb_done at %0d with %0d starts, expected 1 and 0", fin, starts);
    end
  endtask

  task automatic test_backpressure();
    int fin, starts;
    // First result appears at cycle 1+6+1; hold ready low for its first 5 cycles
    run_mb("backpressure", 4'b1111, 6, 1'b0, 0, 8, 5, 0, fin, starts);
    n_checks++;
    if (fin !== 4 * 8 + 1 + 5) begin
      n_errors++;
      $display("FAIL backpressure: mb_done at %0d, expected %0d", fin, 4 * 8 + 1 + 5);
    end
  endtask

  task automatic test_timeout();
    int fin, starts;
    run_mb("timeout", 4'b1011, 5, 1'b1, 0, -1, 0, 0, fin, starts);
    n_checks++;
    if (fin !== 2 + TIMEOUT || starts !== 1) begin
      n_errors++;
      $display("FAIL timeout: mb_done at %0d with %0d starts, expected %0d and 1", fin, starts, 2 + TIMEOUT);
    end
    run_mb("after_timeout", 4'b0110, 3, 1'b0, 20, -1, 0, 0, fin, starts);
  endtask

  task automatic test_reset_mid();
    int fin, starts;
    // Mode 1 waits over cycles 14..23 with latency 10
    run_mb("reset_mid", 4'b1111, 10, 1'b0, 0, -1, 0, 18, fin, starts);
    n_checks++;
    if (fin !== -1 || starts !== 2) begin
      n_errors++;
      $display("FAIL reset_mid: mb_done at %0d with %0d starts, expected none and 2", fin, starts);
    end
    run_mb("after_reset", 4'b1001, 7, 1'b0, 20, -1, 0, 0, fin, starts);
  endtask

  task automatic test_random();
    int fin, starts;
    for (int i = 0; i < 20; i++) begin
      run_mb("random", 4'($urandom), int'($urandom_range(1, 20)), ($urandom_range(99) < 8),
             int'($urandom_range(0, 60)), -1, 0, 0, fin, starts);
    end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_empty_mask();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
